// File: rtl/packet_dispatcher.sv
// packet_dispatcher: captures the first HEADER_BEATS beats of each ingress
// frame while steering the header buffer/parser, issues one TCAM lookup, then
// either replays the captured beats and passes the rest of the frame through
// with tdest taken from the match address, or drops the whole frame.
module packet_dispatcher #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_DEST_WIDTH = 2,
  parameter int HEADER_BEATS    = 3,
  parameter int COUNTER_WIDTH   = $clog2(HEADER_BEATS+1),
  parameter int STATE_WIDTH     = 3,
  parameter int TCAM_ADDR_WIDTH = 4,
  parameter int LOOKUP_TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  // ingress
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  // egress
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_tdest,
  // header buffer control
  output logic [STATE_WIDTH-1:0]     parser_state,
  output logic [COUNTER_WIDTH-1:0]   parser_count,
  // TCAM
  output logic                       lookup_req,
  input  logic                       tcam_match_valid,
  input  logic                       tcam_match,
  input  logic [TCAM_ADDR_WIDTH-1:0] tcam_match_addr,
  // statistics
  output logic [31:0]                fwd_count,
  output logic [31:0]                drop_count
);

  localparam int TW = $clog2(LOOKUP_TIMEOUT+1);
  localparam logic [COUNTER_WIDTH-1:0] LAST_IDX  = COUNTER_WIDTH'(HEADER_BEATS-1);
  localparam logic [COUNTER_WIDTH-1:0] ONE_BEAT  = COUNTER_WIDTH'(1);
  localparam logic [TW-1:0]            TMO_LIMIT = TW'(LOOKUP_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE               = 3'd0,
    PARSE_DATA         = 3'd1,
    CONTROL            = 3'd2,
    SEND_ANALYSED_DATA = 3'd3,
    SEND_REMAIN        = 3'd4,
    DROP               = 3'd5
  } state_t;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [AXIS_KEEP_WIDTH-1:0] keep;
  } beat_t;

  state_t                     state;
  beat_t                      hdr [HEADER_BEATS];
  beat_t                      in_beat;
  beat_t                      out_beat;
  logic                       out_valid;
  logic                       out_last;
  logic [AXIS_DEST_WIDTH-1:0] dest;
  logic [COUNTER_WIDTH-1:0]   idx;       // next header slot while in PARSE_DATA
  logic [COUNTER_WIDTH-1:0]   hdr_n;     // number of captured header beats
  logic [COUNTER_WIDTH-1:0]   rp;        // replay pointer (beat on the output)
  logic                       short_frm; // frame ended inside the header
  logic                       req_sent;
  logic [TW-1:0]              tmo_cnt;
  logic                       hdr_phase;
  logic                       s_hs;

  assign in_beat      = '{data: s_axis_tdata, keep: s_axis_tkeep};
  assign hdr_phase    = (state == IDLE) || (state == PARSE_DATA);
  assign s_hs         = s_axis_tvalid && s_axis_tready;
  assign m_axis_tdest = dest;

  // Upper match-address bits have no use once tdest is narrower.
  generate
    if (TCAM_ADDR_WIDTH > AXIS_DEST_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^tcam_match_addr[TCAM_ADDR_WIDTH-1:AXIS_DEST_WIDTH];
    end
  endgenerate

  // Ingress ready and egress mux: registered replay, combinational pass-through.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = out_valid;
    m_axis_tdata  = out_beat.data;
    m_axis_tkeep  = out_beat.keep;
    m_axis_tlast  = out_last;
    case (state)
      IDLE, PARSE_DATA, DROP: s_axis_tready = 1'b1;
      SEND_REMAIN: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tlast  = s_axis_tlast;
      end
      default: ;
    endcase
  end

  // Buffer steering: PARSE_DATA only on an accepted header beat so the buffer
  // writes one slot per beat; a header stall shows CONTROL so it never clears.
  always_comb begin
    parser_state = STATE_WIDTH'(state);
    parser_count = (state == PARSE_DATA) ? idx : '0;
    if (hdr_phase) begin
      if (s_hs)                     parser_state = STATE_WIDTH'(PARSE_DATA);
      else if (state == PARSE_DATA) parser_state = STATE_WIDTH'(CONTROL);
      else                          parser_state = STATE_WIDTH'(IDLE);
    end
  end

  // Replay store: one slot per accepted header beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HEADER_BEATS; i++) hdr[i] <= '0;
    end else if (hdr_phase && s_hs) begin
      hdr[parser_count] <= in_beat;
    end
  end

  // Main FSM with registered replay outputs, lookup strobe and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      hdr_n      <= '0;
      rp         <= '0;
      short_frm  <= 1'b0;
      req_sent   <= 1'b0;
      lookup_req <= 1'b0;
      tmo_cnt    <= '0;
      out_beat   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      dest       <= '0;
      fwd_count  <= '0;
      drop_count <= '0;
    end else begin
      lookup_req <= 1'b0;
      case (state)
        IDLE: begin
          if (s_hs) begin
            if (s_axis_tlast || HEADER_BEATS == 1) begin
              hdr_n     <= ONE_BEAT;
              short_frm <= s_axis_tlast;
              state     <= CONTROL;
            end else begin
              idx   <= ONE_BEAT;
              state <= PARSE_DATA;
            end
          end
        end
        PARSE_DATA: begin
          if (s_hs) begin
            if (s_axis_tlast || idx == LAST_IDX) begin
              hdr_n     <= idx + 1'b1;
              short_frm <= s_axis_tlast;
              state     <= CONTROL;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        CONTROL: begin
          // First cycle lets the buffer register the key; strobe goes out next.
          if (!req_sent) begin
            lookup_req <= 1'b1;
            req_sent   <= 1'b1;
            tmo_cnt    <= '0;
          end else if (tcam_match_valid && tcam_match) begin
            req_sent  <= 1'b0;
            dest      <= tcam_match_addr[AXIS_DEST_WIDTH-1:0];
            out_beat  <= hdr[0];
            out_valid <= 1'b1;
            out_last  <= short_frm && (hdr_n == ONE_BEAT);
            rp        <= '0;
            state     <= SEND_ANALYSED_DATA;
          end else if (tcam_match_valid || tmo_cnt == TMO_LIMIT) begin
            // miss, or no answer: a valid on the limit cycle still wins above
            req_sent <= 1'b0;
            if (short_frm) begin
              drop_count <= drop_count + 1'b1;
              state      <= IDLE;
            end else begin
              state <= DROP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SEND_ANALYSED_DATA: begin
          if (m_axis_tready) begin
            if (rp == hdr_n - 1'b1) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_beat  <= '0;
              rp        <= '0;
              if (short_frm) begin
                fwd_count <= fwd_count + 1'b1;
                state     <= IDLE;
              end else begin
                state <= SEND_REMAIN;
              end
            end else begin
              rp       <= rp + 1'b1;
              out_beat <= hdr[rp + 1'b1];
              out_last <= short_frm && (rp + 1'b1 == hdr_n - 1'b1);
            end
          end
        end
        SEND_REMAIN: begin
          if (s_hs && s_axis_tlast) begin
            fwd_count <= fwd_count + 1'b1;
            state     <= IDLE;
          end
        end
        DROP: begin
          if (s_hs && s_axis_tlast) begin
            drop_count <= drop_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_dispatcher.sv
// Directed bench for packet_dispatcher: hit, miss, short frame, timeout with
// boundary-latency recovery, ingress/egress stalls and reset mid-frame.
module tb_packet_dispatcher;

  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tdest;
  logic [2:0]  parser_state;
  logic [1:0]  parser_count;
  logic        lookup_req;
  logic        tcam_match_valid;
  logic        tcam_match;
  logic [3:0]  tcam_match_addr;
  logic [31:0] fwd_count;
  logic [31:0] drop_count;

  packet_dispatcher dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .parser_state(parser_state), .parser_count(parser_count),
    .lookup_req(lookup_req),
    .tcam_match_valid(tcam_match_valid), .tcam_match(tcam_match),
    .tcam_match_addr(tcam_match_addr),
    .fwd_count(fwd_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [1:0]  dst;
  } eb_t;

  eb_t  out_q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   nreq = 0;
  int   resp_mode = 0;   // 0 silent, 1 hit, 2 miss
  int   resp_lat  = 1;
  logic [3:0] resp_addr = '0;
  bit   stall_arm  = 0;
  bit   stall_done = 0;
  int   stall_bad  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // egress capture and lookup strobe count, sampled mid-cycle
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready)
      out_q.push_back('{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast, dst: m_axis_tdest});
    if (lookup_req) nreq++;
  end

  // TCAM model: answers resp_lat cycles after the strobe cycle
  initial begin
    tcam_match_valid = 1'b0;
    tcam_match       = 1'b0;
    tcam_match_addr  = '0;
    forever begin
      @(negedge clk);
      if (lookup_req && resp_mode != 0) begin
        @(posedge clk);
        repeat (resp_lat - 1) @(posedge clk);
        #1;
        tcam_match_valid = 1'b1;
        tcam_match       = (resp_mode == 1);
        tcam_match_addr  = resp_addr;
        @(posedge clk); #1;
        tcam_match_valid = 1'b0;
        tcam_match       = 1'b0;
      end
    end
  end

  // egress stall: hold tready low 5 cycles after the first replayed beat
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_arm && out_q.size() >= 1) begin
        eb_t snap;
        logic v;
        m_axis_tready = 1'b0;
        #1;
        snap = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast, dst: m_axis_tdest};
        v = m_axis_tvalid;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (!v || m_axis_tvalid !== 1'b1 || m_axis_tdata !== snap.d || m_axis_tkeep !== snap.k ||
              m_axis_tlast !== snap.l || m_axis_tdest !== snap.dst)
            stall_bad++;
          @(posedge clk);
        end
        #1;
        m_axis_tready = 1'b1;
        stall_arm  = 0;
        stall_done = 1;
      end
    end
  end

  // Drive a frame of n beats (data base+i), stopping after nsend beats.
  // gN = idle cycles before header beat N. Entry/exit at posedge+1.
  task automatic send_frame(input int n, input int nsend, input logic [63:0] base,
                            input int g0, input int g1, input int g2, input bit cps);
    int g;
    bit hs;
    int w;
    for (int i = 0; i < nsend; i++) begin
      g = (i == 0) ? g0 : (i == 1) ? g1 : (i == 2) ? g2 : 0;
      for (int k = 0; k < g; k++) begin
        s_axis_tvalid = 1'b0;
        #1;
        if (cps) chk($sformatf("ps_gap%0d", i), parser_state, (i == 0) ? 64'd0 : 64'd2);
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 64'(i);
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = (i == n - 1);
      hs = 0;
      w  = 0;
      while (!hs && w < 200) begin
        #1;
        if (s_axis_tready) begin
          hs = 1;
          if (cps && i < H) begin
            chk($sformatf("ps_hs%0d", i), parser_state, 64'd1);
            chk($sformatf("pc_hs%0d", i), parser_count, 64'(i));
          end
        end
        @(posedge clk); #1;
        w++;
      end
      chk($sformatf("accept_beat%0d", i), hs, 1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int w = 0;
    while (out_q.size() < n && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  task automatic check_frame(input string tag, input int n, input logic [63:0] base, input logic [1:0] dst);
    chk({tag, "_nbeats"}, 64'(out_q.size()), 64'(n));
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), out_q[i].d, base + 64'(i));
      chk($sformatf("%s_keep%0d", tag, i), out_q[i].k, 8'hFF);
      chk($sformatf("%s_last%0d", tag, i), out_q[i].l, (i == n - 1));
      chk($sformatf("%s_dest%0d", tag, i), out_q[i].dst, dst);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_pstate",   parser_state, 0);
    chk("rst_pcount",   parser_count, 0);
    chk("rst_lookup",   lookup_req, 0);
    chk("rst_fwd",      fwd_count, 0);
    chk("rst_drop",     drop_count, 0);
    chk("rst_tdest",    m_axis_tdest, 0);
    @(posedge clk); #1;

    // hit: 8 beats, L=2, addr 6 -> tdest 2
    resp_mode = 1; resp_lat = 2; resp_addr = 4'h6;
    out_q.delete(); nreq = 0;
    send_frame(8, 8, 64'h1000, 0, 0, 0, 1);
    wait_out(8);
    check_frame("hit", 8, 64'h1000, 2'd2);
    chk("hit_nreq", nreq, 1);
    chk("hit_fwd",  fwd_count, 1);
    chk("hit_drop", drop_count, 0);

    // miss: whole frame consumed, nothing out
    resp_mode = 2; resp_lat = 3;
    out_q.delete(); nreq = 0;
    send_frame(8, 8, 64'h2000, 0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    chk("miss_nout", out_q.size(), 0);
    chk("miss_nreq", nreq, 1);
    chk("miss_drop", drop_count, 1);
    chk("miss_fwd",  fwd_count, 1);

    // short frame: 2 beats, L=1, addr 9 -> tdest 1, back to IDLE after replay
    resp_mode = 1; resp_lat = 1; resp_addr = 4'h9;
    out_q.delete();
    send_frame(2, 2, 64'h3000, 0, 0, 0, 0);
    wait_out(2);
    check_frame("short", 2, 64'h3000, 2'd1);
    chk("short_fwd", fwd_count, 2);
    m_axis_tready = 1'b0;
    #1;
    chk("short_idle_ready", s_axis_tready, 1);
    m_axis_tready = 1'b1;
    @(posedge clk); #1;

    // timeout: no answer -> dropped
    resp_mode = 0;
    out_q.delete(); nreq = 0;
    send_frame(8, 8, 64'h4000, 0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    chk("tmo_nout", out_q.size(), 0);
    chk("tmo_nreq", nreq, 1);
    chk("tmo_drop", drop_count, 2);

    // recovery with answer on the last allowed cycle (L=16), addr B -> tdest 3
    resp_mode = 1; resp_lat = 16; resp_addr = 4'hB;
    out_q.delete();
    send_frame(4, 4, 64'h5000, 0, 0, 0, 0);
    wait_out(4);
    check_frame("edge_lat", 4, 64'h5000, 2'd3);
    chk("edge_lat_fwd",  fwd_count, 3);
    chk("edge_lat_drop", drop_count, 2);

    // stalls: ingress gaps in header, 5-cycle egress stall mid-replay
    resp_mode = 1; resp_lat = 2; resp_addr = 4'h5;
    out_q.delete();
    stall_done = 0; stall_bad = 0; stall_arm = 1;
    send_frame(6, 6, 64'h6000, 1, 2, 1, 1);
    wait_out(6);
    check_frame("stall", 6, 64'h6000, 2'd1);
    chk("stall_seen",   stall_done, 1);
    chk("stall_stable", stall_bad, 0);
    chk("stall_fwd",    fwd_count, 4);

    // reset while passing the remainder through
    resp_mode = 1; resp_lat = 1; resp_addr = 4'h2;
    out_q.delete();
    send_frame(8, 5, 64'h7000, 0, 0, 0, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h7005;
    s_axis_tkeep  = 8'hFF;
    s_axis_tlast  = 1'b0;
    #1;
    chk("remain_valid", m_axis_tvalid, 1);
    chk("remain_data",  m_axis_tdata, 64'h7005);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mrst_m_tvalid", m_axis_tvalid, 0);
    chk("mrst_tdata",    m_axis_tdata, 0);
    chk("mrst_tkeep",    m_axis_tkeep, 0);
    chk("mrst_tlast",    m_axis_tlast, 0);
    chk("mrst_tdest",    m_axis_tdest, 0);
    chk("mrst_lookup",   lookup_req, 0);
    chk("mrst_pstate",   parser_state, 0);
    chk("mrst_pcount",   parser_count, 0);
    chk("mrst_fwd",      fwd_count, 0);
    chk("mrst_drop",     drop_count, 0);
    chk("mrst_s_tready", s_axis_tready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
